// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - opcode constants shared by the ALU, its UART front end and benches
package alu_defs_pkg;

    localparam int NB_OP = 6;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    function automatic logic is_supported(input logic [NB_OP-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_supported = 1'b1;
            default:                        is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - gathers A, B, opcode bytes from the UART receiver and hands the ALU result to the transmitter
module uart_alu_interface #(
    parameter int DBIT  = 8,
    parameter int NB_OP = alu_defs_pkg::NB_OP
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_opcode,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_err_opcode
);
    import alu_defs_pkg::*;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DBIT-1:0]  data_a_q, data_a_d;
    logic [DBIT-1:0]  data_b_q, data_b_d;
    logic [NB_OP-1:0] opcode_q, opcode_d;
    logic [DBIT-1:0]  tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             err_q, err_d;
    logic             rx_done_q;
    logic             byte_stb;

    // One strobe per rising edge of rx_done, however long the level is held.
    assign byte_stb = i_rx_done & ~rx_done_q;

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (byte_stb) begin
                    data_a_d = i_rx_data;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (byte_stb) begin
                    data_b_d = i_rx_data;
                    state_d  = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (byte_stb) begin
                    if (is_supported(i_rx_data[NB_OP-1:0])) begin
                        opcode_d = i_rx_data[NB_OP-1:0];
                        state_d  = SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_A;
                    end
                end
            end
            SEND: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                // Bytes arriving here are dropped, even alongside tx_done.
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            rx_done_q  <= i_rx_done;
        end
    end

    assign o_data_a     = data_a_q;
    assign o_data_b     = data_b_q;
    assign o_opcode     = opcode_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_err_opcode = err_q;
    assign o_busy       = (state_q == SEND) | (state_q == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - vector table plus scoreboard bench for uart_alu_interface
module tb_uart_alu_interface;
    import alu_defs_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_opcode;
    logic       o_tx_start, o_busy, o_err_opcode;

    uart_alu_interface dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_opcode(o_opcode),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_err_opcode(o_err_opcode)
    );

    always #5 i_clk = ~i_clk;

    // Environment ALU driven from the DUT's operand registers.
    always_comb begin
        i_alu_result = '0;
        case (o_opcode)
            OP_ADD: i_alu_result = o_data_a + o_data_b;
            OP_SUB: i_alu_result = o_data_a - o_data_b;
            OP_AND: i_alu_result = o_data_a & o_data_b;
            OP_OR:  i_alu_result = o_data_a | o_data_b;
            OP_XOR: i_alu_result = o_data_a ^ o_data_b;
            OP_NOR: i_alu_result = ~(o_data_a | o_data_b);
            OP_SRA: i_alu_result = 8'($signed(o_data_a) >>> o_data_b);
            OP_SRL: i_alu_result = o_data_a >> o_data_b;
            default: i_alu_result = '0;
        endcase
    end

    int start_cnt = 0;
    int err_cnt = 0;
    always @(negedge i_clk) begin
        if (o_tx_start)   start_cnt <= start_cnt + 1;
        if (o_err_opcode) err_cnt   <= err_cnt + 1;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] sb_q[$];
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one byte from a negedge; watch for tx_start while the level is held.
    task automatic send_byte(input logic [7:0] d, input int hold, input bit is_op, input bit ok);
        int  win;
        int  lat;
        bit  seen;
        int  s0;
        int  e0;
        logic [7:0] txd;
        logic       busy;
        win  = (hold > 6) ? hold : 6;
        seen = 0;
        lat  = 0;
        txd  = '0;
        busy = 0;
        s0   = start_cnt;
        e0   = err_cnt;
        @(negedge i_clk);
        i_rx_data = d;
        i_rx_done = 1'b1;
        for (int c = 1; c <= win; c++) begin
            @(negedge i_clk);
            if (is_op && !seen && o_tx_start) begin
                seen = 1;
                lat  = c;
                txd  = o_tx_data;
                busy = o_busy;
            end
            if (c == hold) i_rx_done = 1'b0;
        end
        i_rx_done = 1'b0;
        if (is_op && ok) begin
            check("start_seen", 32'(seen), 32'd1);
            check("latency", lat, 32'd2);
            check("busy_at_start", 32'(busy), 32'd1);
            check("one_start", start_cnt - s0, 32'd1);
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                check("tx_data", 32'(txd), 32'(sb_q.pop_front()));
            end
        end else if (is_op) begin
            check("no_start_bad_op", start_cnt - s0, 32'd0);
            check("err_pulse", err_cnt - e0, 32'd1);
            check("idle_after_err", 32'(o_busy), 32'd0);
        end
    endtask

    task automatic finish_tx();
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check("busy_after_done", 32'(o_busy), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v, input bit do_finish);
        send_byte(v.a, v.hold, 0, 0);
        send_byte(v.b, v.hold, 0, 0);
        sb_q.push_back(v.exp);
        send_byte(v.op, v.hold, 1, 1);
        check("data_a", 32'(o_data_a), 32'(v.a));
        check("data_b", 32'(o_data_b), 32'(v.b));
        check("opcode", 32'(o_opcode), 32'(v.op[5:0]));
        check("busy_wait_tx", 32'(o_busy), 32'd1);
        if (do_finish) finish_tx();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_data_a, o_data_b, 2'b00, o_opcode, 5'd0, o_tx_start, o_busy, o_err_opcode},
              32'd0);
        check({name, "_txd"}, 32'(o_tx_data), 32'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 1};
        vecs[1] = '{8'hF0, 8'h0F, 8'h27, 8'h00, 20};
        vecs[2] = '{8'h80, 8'h01, 8'h03, 8'hC0, 1};
        vecs[3] = '{8'hCC, 8'hAA, 8'h24, 8'h88, 2};
        vecs[4] = '{8'hCC, 8'hAA, 8'h25, 8'hEE, 1};
        vecs[5] = '{8'hCC, 8'hAA, 8'h26, 8'h66, 3};
        vecs[6] = '{8'h80, 8'h03, 8'h02, 8'h10, 1};
        vecs[7] = '{8'h03, 8'h05, 8'h22, 8'hFE, 1};
        vecs[8] = '{8'h7F, 8'h01, 8'h20, 8'h80, 1};
        vecs[9] = '{8'h09, 8'h01, 8'h22, 8'h08, 1};

        repeat (2) @(negedge i_clk);
        check_all_zero("reset_state");
        i_reset = 1'b0;

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], 1);

        // Unsupported opcode: operands kept, opcode register untouched.
        send_byte(8'h01, 1, 0, 0);
        send_byte(8'h02, 1, 0, 0);
        send_byte(8'h3F, 1, 1, 0);
        check("opcode_kept", 32'(o_opcode), 32'h22);
        check("a_after_bad", 32'(o_data_a), 32'h01);
        v = '{8'h09, 8'h01, 8'h22, 8'h08, 1};
        apply_vec(v, 1);

        // Dropped bytes in WAIT_TX, one coinciding with tx_done.
        v = '{8'h05, 8'h03, 8'h20, 8'h08, 1};
        apply_vec(v, 0);
        send_byte(8'hAA, 1, 0, 0);
        check("busy_still", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        i_rx_data = 8'hAA;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("drop_a_kept", 32'(o_data_a), 32'h05);
        check("drop_idle", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check("drop_a_kept2", 32'(o_data_a), 32'h05);
        apply_vec(vecs[4], 1);

        // Async reset while in WAIT_OP.
        send_byte(8'h11, 1, 0, 0);
        send_byte(8'h22, 1, 0, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_all_zero("reset_wait_op");
        @(negedge i_clk);
        i_reset = 1'b0;
        apply_vec(vecs[0], 1);

        // Async reset while in WAIT_TX.
        apply_vec(vecs[2], 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_all_zero("reset_wait_tx");
        @(negedge i_clk);
        i_reset = 1'b0;
        apply_vec(vecs[3], 1);

        // A stray tx_done while idle must not disturb the next sequence.
        finish_tx();
        apply_vec(vecs[6], 1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
